// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder among NREQ requesters.
// Defining FP_ADD_ARB_STATS_EN adds saturating op_count / stall_count outputs.

module fp_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  logic        w_swap;
  logic [31:0] w_big;
  logic [31:0] w_sml;
  logic [23:0] w_m_big;
  logic [23:0] w_m_sml;
  logic [23:0] w_m_al;
  logic [7:0]  w_ediff;
  logic [7:0]  w_exp;
  logic [24:0] w_raw;
  logic [24:0] w_norm;
  logic [4:0]  w_lz;

  function automatic logic [4:0] lead_zeros(input logic [24:0] v);
    lead_zeros = 5'd25;
    for (int k = 0; k < 25; k++) begin
      if (v[k]) begin
        lead_zeros = 5'(24 - k);
      end else begin
        lead_zeros = lead_zeros;
      end
    end
  endfunction

  // Align the smaller magnitude, add or subtract, renormalise so the MSB lands on bit 24.
  always_comb begin
    w_swap  = (i_b[30:0] > i_a[30:0]);
    w_big   = w_swap ? i_b : i_a;
    w_sml   = w_swap ? i_a : i_b;
    w_m_big = {|w_big[30:23], w_big[22:0]};
    w_m_sml = {|w_sml[30:23], w_sml[22:0]};
    w_ediff = w_big[30:23] - w_sml[30:23];
    w_m_al  = (w_ediff > 8'd24) ? 24'd0 : (w_m_sml >> w_ediff);
    if (w_big[31] == w_sml[31]) begin
      w_raw = {1'b0, w_m_big} + {1'b0, w_m_al};
    end else begin
      w_raw = {1'b0, w_m_big} - {1'b0, w_m_al};
    end
    w_lz   = lead_zeros(w_raw);
    w_norm = w_raw << w_lz;
    // Bit 24 of w_norm is the hidden bit; the exponent absorbs the carry and the left shift.
    w_exp  = w_big[30:23] + 8'd1 - {3'd0, w_lz};
    if (i_a[30:0] == 31'd0) begin
      o_sum = i_b;
    end else if (i_b[30:0] == 31'd0) begin
      o_sum = i_a;
    end else if (w_raw == 25'd0) begin
      o_sum = 32'd0;
    end else begin
      o_sum = {w_big[31], w_exp, w_norm[23:1]};
    end
  end
endmodule

module fp_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic [NREQ-1:0]      req_rdy,
  output logic                 res_vld,
  output logic [31:0]          res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_rdy
`ifdef FP_ADD_ARB_STATS_EN
  ,
  output logic [15:0]          op_count,
  output logic [15:0]          stall_count
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_gnt_idx;
  logic           w_gnt_any;
  logic           w_xfer;
  logic [31:0]    w_sel_a;
  logic [31:0]    w_sel_b;
  logic           w_sel_sub;
  logic [31:0]    r_op_a;
  logic [31:0]    r_op_b;
  logic [IDW-1:0] r_op_id;
  logic [31:0]    w_sum;
  logic           r_res_vld;
  logic [31:0]    r_res_data;
  logic [IDW-1:0] r_res_id;

  fp_adder u_fp_adder (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_sum (w_sum)
  );

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = {IDW{1'b0}};
    w_cand    = {IDW{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_gnt_any && req_vld[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end else begin
        w_gnt_any = w_gnt_any;
      end
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    w_sel_a   = 32'd0;
    w_sel_b   = 32'd0;
    w_sel_sub = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt_idx == IDW'(k)) begin
        w_sel_a   = req_a[32*k +: 32];
        w_sel_b   = req_b[32*k +: 32];
        w_sel_sub = req_sub[k];
      end else begin
        w_sel_sub = w_sel_sub;
      end
    end
  end

  // Next-state and accept logic; req_rdy only ever asserts in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = {NREQ{1'b0}};
    w_xfer      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_any) begin
          req_rdy     = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx;
          w_xfer      = 1'b1;
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: w_state_nxt = DONE;
      DONE: begin
        if (res_rdy) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, result capture and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= IDW'(NREQ - 1);
      r_op_a     <= 32'd0;
      r_op_b     <= 32'd0;
      r_op_id    <= {IDW{1'b0}};
      r_res_vld  <= 1'b0;
      r_res_data <= 32'd0;
      r_res_id   <= {IDW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= {w_sel_b[31] ^ w_sel_sub, w_sel_b[30:0]};
            r_op_id  <= w_gnt_idx;
            r_rr_ptr <= w_gnt_idx;
          end
        end
        CALC: begin
          r_res_data <= w_sum;
          r_res_id   <= r_op_id;
          r_res_vld  <= 1'b1;
        end
        DONE: begin
          if (res_rdy) begin
            r_res_vld <= 1'b0;
          end
        end
        default: r_res_vld <= 1'b0;
      endcase
    end
  end

  assign res_vld  = r_res_vld;
  assign res_data = r_res_data;
  assign res_id   = r_res_id;

`ifdef FP_ADD_ARB_STATS_EN
  logic [15:0] r_op_count;
  logic [15:0] r_stall_count;

  // Saturating completion and back-pressure counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count    <= 16'd0;
      r_stall_count <= 16'd0;
    end else begin
      if (r_res_vld && res_rdy && (r_op_count != 16'hFFFF)) begin
        r_op_count <= r_op_count + 16'd1;
      end
      if ((r_state == DONE) && !res_rdy && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign op_count    = r_op_count;
  assign stall_count = r_stall_count;
`endif
endmodule
